screen_seq_ctrl: RTL and testbench
==================================

Name: screen_seq_ctrl

Overview:
- Game-screen sequencer and overlay scheduler for the 640x480 VGA pipeline.
- Tracks lives and runs the title → play → death-flash → game-over flow, timed in frames.
- Decides which full-width overlay image (title or game-over banner) owns the shared overlay ROM.
- Generates that ROM's read address and a pixel-valid strobe aligned to the ROM read data, for the colour-key mux downstream.

Parameters:
- LIVES, 3: lives at game start; legal range 1..7.
- FLASH_FRAMES, 60: frames spent in the death flash before play resumes.
- HOLD_FRAMES, 120: frames the banner is shown before start is accepted.
- OVL_Y0, 160: first overlay row.
- OVL_H, 160: overlay height in rows.
- OVL_W, 640: overlay width in pixels, also the ROM row pitch.
- RD_LAT, 1: overlay ROM read latency in clocks; legal range 1..3.

Ports:
- clk  in  1  pixel clock; one clock, used for all logic.
- rst  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-clock pulse per frame at vblank start.
- x  in  10  current pixel column.
- y  in  10  current pixel row.
- start_btn  in  1  raw push-button, asynchronous to clk.
- hit  in  1  one-clock pulse: player killed.
- playing  out  1  high in PLAY.
- gameover  out  1  high in OVER_HOLD and OVER_WAIT.
- blink  out  1  sprite-hide strobe during FLASH.
- lives_left  out  3  remaining lives.
- rom_addr  out  17  overlay ROM address, registered.
- ovl_sel  out  2  overlay bank: 0 none, 1 title, 2 banner; registered with rom_addr.
- ovl_valid  out  1  high when ROM data currently on its output is an in-region overlay pixel.

Behaviour:
- Reset (rst=0, async): state=TITLE, lives_left=0, frame counter=0, synchroniser and edge flops=0; playing=0, gameover=0, blink=0, rom_addr=0, ovl_sel=0, ovl_valid=0.
- Reset asserted mid-game or mid-frame returns to TITLE immediately; no pending event survives.
- start_btn path: 2-flop synchroniser, then rising-edge detect.
  - start_evt is high 3 clocks after start_btn rises, for exactly 1 clock.
  - A held button yields a single event.
- FSM, one transition per clock:
  - TITLE: start_evt → PLAY; lives_left<=LIVES.
  - PLAY: on hit, lives_left<=lives_left-1. If lives_left was 1, go to OVER_HOLD; otherwise go to FLASH.
  - FLASH: count frame_tick; when count reaches FLASH_FRAMES → PLAY. Further hits are ignored.
  - OVER_HOLD: count frame_tick; when count reaches HOLD_FRAMES → OVER_WAIT. start_evt is ignored.
  - OVER_WAIT: start_evt → TITLE.
- Frame counter:
  - 8 bits, cleared on every state entry, saturating at 255.
  - Increments only on frame_tick.
- Simultaneous events:
  - hit with frame_tick in PLAY: hit is processed; the tick is irrelevant in PLAY.
  - The final frame_tick of FLASH coinciding with hit: the transition to PLAY wins and the hit is dropped.
- lives_left never underflows; it stays 0 through OVER_* and TITLE.
- blink = frame counter bit 2 while in FLASH, else 0.
- Address stage (1 clock):
  - in_reg = (x < OVL_W) && (y >= OVL_Y0) && (y < OVL_Y0+OVL_H).
  - rom_addr <= ((y-OVL_Y0)<<9) + ((y-OVL_Y0)<<7) + x, in 17-bit arithmetic; this equals (y-OVL_Y0)*640+x. Value is held at 0 when !in_reg.
  - ovl_sel <= 1 in TITLE, 2 in OVER_*, 0 otherwise.
- Valid alignment:
  - ovl_valid = (in_reg && ovl_sel!=0), delayed RD_LAT clocks after rom_addr.
  - Total latency from x/y to ovl_valid is 1+RD_LAT clocks.
- Boundaries:
  - Row OVL_Y0+OVL_H-1, col 639 gives rom_addr=102399.
  - x = 640..799 (blanking) and y outside the band: valid=0.
  - A state change mid-frame takes effect on the next pixel; no frame-boundary deferral.

Optional Feature:
- Macro: SCREEN_SEQ_BANNER_BLINK_EN.
- Defined: in OVER_WAIT, ovl_valid is additionally masked while a free-running frame counter bit 5 is 1, so the banner blinks at ~32-frame half-period. This counter is cleared on OVER_WAIT entry.
- Undefined: the banner is steady; the extra counter is absent.

Decomposition:
- Package screen_pkg:
  - State enum: TITLE, PLAY, FLASH, OVER_HOLD, OVER_WAIT.
  - ovl_sel codes: OVL_NONE, OVL_TITLE, OVL_BANNER.
  - SCREEN_W=640, SCREEN_H=480.
- Sub-module ovl_addr_gen holds the region compare, shift-add address and RD_LAT delay line.

Test Plan:
- Reset, then start_btn pulse held 10 clocks → exactly one start_evt 3 clocks after the rise; state PLAY; lives_left=3; playing=1.
- Apply hit, then 60 frame_ticks → blink toggles every 4 ticks; return to PLAY on the 60th tick. A hit injected at tick 30 does not change lives_left=2.
- Three hits separated by full flashes → after the third, lives_left=0 and gameover=1. start during the 120-tick hold is ignored; start after the hold → TITLE.
- Sweep x=0..799 at y=159, 160, 319, 320 in OVER_WAIT:
  - y=159 and y=320: no valid pixels.
  - y=160: rom_addr 0..639.
  - y=319: rom_addr 101760..102399.
  - ovl_valid lags rom_addr by RD_LAT (test with 1 and 2).
- Drop rst mid-FLASH → all outputs 0 the same clock; after release, state is TITLE and ovl_sel=1 inside the band.
- With SCREEN_SEQ_BANNER_BLINK_EN defined → ovl_valid is suppressed for frames 32..63 of OVER_WAIT. Undefined → continuous.

Source files
------------

// File: rtl/screen_seq_ctrl_pkg.sv
// screen_pkg: shared state codes, overlay bank codes and screen geometry for the screen sequencer.
package screen_pkg;
  typedef enum logic [2:0] {TITLE, PLAY, FLASH, OVER_HOLD, OVER_WAIT} state_t;
  typedef enum logic [1:0] {OVL_NONE, OVL_TITLE, OVL_BANNER} ovl_t;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/screen_seq_ctrl_ovl_addr_gen.sv
// ovl_addr_gen: overlay region compare, shift-add ROM address and valid delay matched to ROM read latency.
module ovl_addr_gen #(
  parameter int OVL_Y0 = 160,
  parameter int OVL_H  = 160,
  parameter int OVL_W  = 640,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [1:0]  sel_in,
  input  logic        mask,
  output logic [16:0] rom_addr,
  output logic [1:0]  ovl_sel,
  output logic        ovl_valid
);
  localparam logic [10:0] X_HI = 11'(OVL_W);
  localparam logic [10:0] Y_LO = 11'(OVL_Y0);
  localparam logic [10:0] Y_HI = 11'(OVL_Y0 + OVL_H);
  logic        in_reg;
  logic [16:0] dy, addr;
  logic [RD_LAT:0] vp;
  assign in_reg = ({1'b0, x} < X_HI) && ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);
  assign dy     = {7'd0, y} - 17'(OVL_Y0);
  // row pitch 640 = 512 + 128
  assign addr   = in_reg ? (dy << 9) + (dy << 7) + {7'd0, x} : '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_addr <= '0;
      ovl_sel  <= '0;
      vp       <= '0;
    end else begin
      rom_addr <= addr;
      ovl_sel  <= sel_in;
      vp       <= {vp[RD_LAT-1:0], in_reg && (sel_in != 2'd0) && !mask};
    end
  end
  assign ovl_valid = vp[RD_LAT];
endmodule

// File: rtl/screen_seq_ctrl.sv
// screen_seq_ctrl: title/play/flash/game-over sequencer and overlay ROM scheduler; SCREEN_SEQ_BANNER_BLINK_EN blinks the banner.
module screen_seq_ctrl
  import screen_pkg::*;
#(
  parameter int LIVES        = 3,
  parameter int FLASH_FRAMES = 60,
  parameter int HOLD_FRAMES  = 120,
  parameter int OVL_Y0       = 160,
  parameter int OVL_H        = 160,
  parameter int OVL_W        = SCREEN_W,
  parameter int RD_LAT       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        start_btn,
  input  logic        hit,
  output logic        playing,
  output logic        gameover,
  output logic        blink,
  output logic [2:0]  lives_left,
  output logic [16:0] rom_addr,
  output logic [1:0]  ovl_sel,
  output logic        ovl_valid
);
  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic       s1, s2, s3, start_evt, mask;
  ovl_t       sel_nxt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) {s1, s2, s3} <= '0;
    else {s1, s2, s3} <= {start_btn, s1, s2};
  end
  assign start_evt = s2 && !s3;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= TITLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    unique case (state)
      TITLE:     if (start_evt) state_nxt = PLAY;
      PLAY:      if (hit) state_nxt = (lives_left == 3'd1) ? OVER_HOLD : FLASH;
      FLASH:     if (frame_tick && cnt == 8'(FLASH_FRAMES - 1)) state_nxt = PLAY;
      OVER_HOLD: if (frame_tick && cnt == 8'(HOLD_FRAMES - 1)) state_nxt = OVER_WAIT;
      OVER_WAIT: if (start_evt) state_nxt = TITLE;
      default:   state_nxt = TITLE;
    endcase
  end
  always_comb begin
    playing  = state == PLAY;
    gameover = state == OVER_HOLD || state == OVER_WAIT;
    blink    = state == FLASH && cnt[2];
    sel_nxt  = state == TITLE ? OVL_TITLE : gameover ? OVL_BANNER : OVL_NONE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      lives_left <= '0;
    end else begin
      cnt <= (state_nxt != state) ? 8'd0 : frame_tick ? sat_inc(cnt) : cnt;
      if (state == TITLE && start_evt) lives_left <= 3'(LIVES);
      else if (state == PLAY && hit && lives_left != 3'd0) lives_left <= lives_left - 3'd1;
    end
  end
`ifdef SCREEN_SEQ_BANNER_BLINK_EN
  logic [5:0] bcnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bcnt <= '0;
    else bcnt <= (state_nxt == OVER_WAIT && state != OVER_WAIT) ? 6'd0 : frame_tick ? bcnt + 6'd1 : bcnt;
  end
  assign mask = state == OVER_WAIT && bcnt[5];
`else
  assign mask = 1'b0;
`endif
  ovl_addr_gen #(.OVL_Y0(OVL_Y0), .OVL_H(OVL_H), .OVL_W(OVL_W), .RD_LAT(RD_LAT)) u_addr (
    .clk(clk), .rst(rst), .x(x), .y(y), .sel_in(sel_nxt), .mask(mask),
    .rom_addr(rom_addr), .ovl_sel(ovl_sel), .ovl_valid(ovl_valid)
  );
endmodule

// File: tb/tb_screen_seq_ctrl.sv
// tb_screen_seq_ctrl: scenario tasks with a queue scoreboard for the overlay pipeline (RD_LAT 1 and 2 instances).
module tb_screen_seq_ctrl;
  logic clk = 0, rst = 0, frame_tick = 0, start_btn = 0, hit = 0;
  logic [9:0] x = 0, y = 0;
  logic playing, gameover, blink, ovl_valid;
  logic [2:0] lives_left;
  logic [16:0] rom_addr;
  logic [1:0] ovl_sel;
  logic p2, g2, b2, ov2;
  logic [2:0] l2;
  logic [16:0] ra2;
  logic [1:0] os2;
  int checks = 0, failures = 0;
  int aq[$];
  bit vq1[$], vq2[$];

  screen_seq_ctrl dut (.clk(clk), .rst(rst), .frame_tick(frame_tick), .x(x), .y(y), .start_btn(start_btn), .hit(hit),
    .playing(playing), .gameover(gameover), .blink(blink), .lives_left(lives_left), .rom_addr(rom_addr),
    .ovl_sel(ovl_sel), .ovl_valid(ovl_valid));
  screen_seq_ctrl #(.RD_LAT(2)) dut2 (.clk(clk), .rst(rst), .frame_tick(frame_tick), .x(x), .y(y), .start_btn(start_btn), .hit(hit),
    .playing(p2), .gameover(g2), .blink(b2), .lives_left(l2), .rom_addr(ra2), .ovl_sel(os2), .ovl_valid(ov2));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  task automatic tick(input bit h);
    frame_tick = 1; hit = h;
    @(negedge clk);
    frame_tick = 0; hit = 0;
  endtask

  task automatic pulse_hit;
    hit = 1;
    @(negedge clk);
    hit = 0;
  endtask

  task automatic press(input int n);
    start_btn = 1;
    repeat (n) @(negedge clk);
    start_btn = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 0; x = 10'd100; y = 10'd200;
    repeat (2) @(negedge clk);
    checks++;
    if ({playing, gameover, blink, lives_left, rom_addr, ovl_sel, ovl_valid, ov2} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got pl=%0b go=%0b bl=%0b lv=%0d ra=%0d sel=%0d v=%0b v2=%0b exp all 0",
        playing, gameover, blink, lives_left, rom_addr, ovl_sel, ovl_valid, ov2);
    end
    rst = 1; x = 10'd799; y = 10'd0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_start;
    start_btn = 1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if (playing !== (i >= 3)) begin
        failures++;
        $display("FAIL start_latency clk=%0d got=%0b exp=%0b", i, playing, i >= 3);
      end
    end
    start_btn = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (lives_left !== 3'd3 || playing !== 1'b1) begin
      failures++;
      $display("FAIL start_lives got lv=%0d pl=%0b exp lv=3 pl=1", lives_left, playing);
    end
  endtask

  task automatic test_flash;
    pulse_hit();
    checks++;
    if (lives_left !== 3'd2 || playing !== 1'b0 || gameover !== 1'b0) begin
      failures++;
      $display("FAIL flash_entry got lv=%0d pl=%0b go=%0b exp lv=2 pl=0 go=0", lives_left, playing, gameover);
    end
    for (int t = 1; t <= 60; t++) begin
      tick(0);
      if (t < 60) begin
        checks++;
        if (blink !== 1'((t >> 2) & 1) || playing !== 1'b0) begin
          failures++;
          $display("FAIL flash_blink tick=%0d got bl=%0b pl=%0b exp bl=%0b pl=0", t, blink, playing, (t >> 2) & 1);
        end
      end
      if (t == 30) begin
        pulse_hit();
        checks++;
        if (lives_left !== 3'd2) begin
          failures++;
          $display("FAIL flash_hit_ignored got=%0d exp=2", lives_left);
        end
      end
    end
    checks++;
    if (playing !== 1'b1 || blink !== 1'b0) begin
      failures++;
      $display("FAIL flash_return got pl=%0b bl=%0b exp pl=1 bl=0", playing, blink);
    end
  endtask

  task automatic test_gameover;
    pulse_hit();
    for (int t = 1; t <= 60; t++) tick(t == 60);
    checks++;
    if (playing !== 1'b1 || lives_left !== 3'd1) begin
      failures++;
      $display("FAIL final_tick_hit got pl=%0b lv=%0d exp pl=1 lv=1", playing, lives_left);
    end
    pulse_hit();
    checks++;
    if (lives_left !== 3'd0 || gameover !== 1'b1 || playing !== 1'b0) begin
      failures++;
      $display("FAIL last_life got lv=%0d go=%0b pl=%0b exp lv=0 go=1 pl=0", lives_left, gameover, playing);
    end
    for (int t = 1; t <= 120; t++) begin
      tick(0);
      if (t == 100) begin
        press(10);
        checks++;
        if (gameover !== 1'b1) begin
          failures++;
          $display("FAIL hold_ignores_start got go=%0b exp=1", gameover);
        end
      end
    end
    checks++;
    if (gameover !== 1'b1 || lives_left !== 3'd0) begin
      failures++;
      $display("FAIL over_wait got go=%0b lv=%0d exp go=1 lv=0", gameover, lives_left);
    end
  endtask

  task automatic sweep_row(input int row);
    int e;
    bit v, in;
    aq.delete(); vq1.delete(); vq2.delete();
    for (int i = 0; i < 804; i++) begin
      @(negedge clk);
      if (aq.size() > 0) begin
        e = aq.pop_front();
        checks++;
        if (rom_addr !== 17'(e) || ra2 !== 17'(e)) begin
          failures++;
          $display("FAIL sweep_addr y=%0d got=%0d/%0d exp=%0d", row, rom_addr, ra2, e);
        end
      end
      if (vq1.size() > 1) begin
        v = vq1.pop_front();
        checks++;
        if (ovl_valid !== v) begin
          failures++;
          $display("FAIL sweep_valid_lat1 y=%0d got=%0b exp=%0b", row, ovl_valid, v);
        end
      end
      if (vq2.size() > 2) begin
        v = vq2.pop_front();
        checks++;
        if (ov2 !== v) begin
          failures++;
          $display("FAIL sweep_valid_lat2 y=%0d got=%0b exp=%0b", row, ov2, v);
        end
      end
      x = 10'((i < 800) ? i : 799);
      y = 10'(row);
      in = (x < 640) && (row >= 160) && (row < 320);
      aq.push_back(in ? (row - 160) * 640 + int'(x) : 0);
      vq1.push_back(in);
      vq2.push_back(in);
    end
  endtask

  task automatic test_sweep;
    sweep_row(159);
    sweep_row(160);
    checks++;
    if (ovl_sel !== 2'd2) begin
      failures++;
      $display("FAIL sweep_sel got=%0d exp=2", ovl_sel);
    end
    sweep_row(319);
    sweep_row(320);
  endtask

  task automatic test_banner_blink;
    bit e;
    x = 10'd100; y = 10'd200;
    for (int k = 1; k <= 64; k++) begin
      tick(0);
      repeat (3) @(negedge clk);
`ifdef SCREEN_SEQ_BANNER_BLINK_EN
      e = ((k >> 5) & 1) == 0;
`else
      e = 1'b1;
`endif
      checks++;
      if (ovl_valid !== e || ov2 !== e) begin
        failures++;
        $display("FAIL banner_blink frame=%0d got=%0b/%0b exp=%0b", k, ovl_valid, ov2, e);
      end
    end
  endtask

  task automatic test_restart;
    press(10);
    repeat (4) @(negedge clk);
    checks++;
    if (gameover !== 1'b0 || playing !== 1'b0 || lives_left !== 3'd0 || ovl_sel !== 2'd1) begin
      failures++;
      $display("FAIL restart_title got go=%0b pl=%0b lv=%0d sel=%0d exp go=0 pl=0 lv=0 sel=1",
        gameover, playing, lives_left, ovl_sel);
    end
  endtask

  task automatic test_reset_mid;
    press(3);
    pulse_hit();
    repeat (5) tick(0);
    checks++;
    if (blink !== 1'b1) begin
      failures++;
      $display("FAIL mid_flash_blink got=%0b exp=1", blink);
    end
    #2 rst = 0;
    #1;
    checks++;
    if ({playing, gameover, blink, lives_left, rom_addr, ovl_sel, ovl_valid, ov2} !== '0) begin
      failures++;
      $display("FAIL async_reset got pl=%0b go=%0b bl=%0b lv=%0d ra=%0d sel=%0d v=%0b v2=%0b exp all 0",
        playing, gameover, blink, lives_left, rom_addr, ovl_sel, ovl_valid, ov2);
    end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    checks++;
    if (ovl_sel !== 2'd1 || playing !== 1'b0 || lives_left !== 3'd0 || ovl_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_title got sel=%0d pl=%0b lv=%0d v=%0b exp sel=1 pl=0 lv=0 v=0",
        ovl_sel, playing, lives_left, ovl_valid);
    end
    @(negedge clk);
    checks++;
    if (ovl_valid !== 1'b1 || ov2 !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_valid1 got=%0b/%0b exp=1/0", ovl_valid, ov2);
    end
    @(negedge clk);
    checks++;
    if (ov2 !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_valid2 got=%0b exp=1", ov2);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_start();
    test_flash();
    test_gameover();
    test_sweep();
    test_banner_blink();
    test_restart();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
